// File: rtl/max_pool_2x2.sv
// Purpose: streaming 2x2 max-pool of a raster pixel stream, halving width and height.
// Latency: outPixel/outValid register one cycle after the odd-row/odd-column pixel is accepted.
// Backpressure: none; every accepted pixel is consumed and every outValid cycle must be taken.
module max_pool_2x2 #(
    parameter int WORD_SIZE = 8,
    parameter int IN_WIDTH  = 538,
    parameter int IN_HEIGHT = 538
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [WORD_SIZE-1:0] inPixel,
    input  logic                 inValid,
    output logic [WORD_SIZE-1:0] outPixel,
    output logic                 outValid,
    output logic                 outLast,
    output logic                 frameDone
);

    localparam int HALF_W = IN_WIDTH / 2;
    localparam int CW     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int RW     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int IW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [CW-1:0] LAST_COL      = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW      = RW'(IN_HEIGHT - 1);
    // Last column that closes a full horizontal pair; an odd trailing column never does.
    localparam logic [CW-1:0] LAST_PAIR_COL = CW'(2 * HALF_W - 1);
    // Last row that closes a full vertical pair; an odd trailing row is counted but unused.
    localparam logic [RW-1:0] LAST_PAIR_ROW = RW'(2 * (IN_HEIGHT / 2) - 1);

    logic [CW-1:0]        col_cnt;
    logic [RW-1:0]        row_cnt;
    logic [WORD_SIZE-1:0] hold_reg;
    logic [WORD_SIZE-1:0] line_buf [HALF_W];

    logic                 accept;
    logic                 col_wrap;
    logic                 frame_end;
    logic                 pair_done;
    logic                 buf_wr;
    logic                 emit;
    logic [IW-1:0]        buf_idx;
    logic [WORD_SIZE-1:0] buf_rd;
    logic [WORD_SIZE-1:0] h_max;
    logic [WORD_SIZE-1:0] v_max;

    assign accept    = inValid && !clear;
    assign col_wrap  = (col_cnt == LAST_COL);
    assign frame_end = col_wrap && (row_cnt == LAST_ROW);
    // Odd columns always fall inside a complete pair, even when the row width is odd.
    assign pair_done = accept && col_cnt[0];
    // Even rows park their horizontal maxima; an unpaired trailing row writes nothing.
    assign buf_wr    = pair_done && !row_cnt[0] && (row_cnt < LAST_PAIR_ROW);
    assign emit      = pair_done && row_cnt[0];

    assign buf_idx = IW'(col_cnt >> 1);
    assign buf_rd  = line_buf[buf_idx];
    assign h_max   = (inPixel > hold_reg) ? inPixel : hold_reg;
    assign v_max   = (buf_rd > h_max) ? buf_rd : h_max;

    // Raster position counters, horizontal-pair hold register and pooled output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            hold_reg  <= '0;
            outPixel  <= '0;
            outValid  <= 1'b0;
            outLast   <= 1'b0;
            frameDone <= 1'b0;
        end else if (clear) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            outValid  <= 1'b0;
            outLast   <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            outValid  <= emit;
            outLast   <= emit && (col_cnt == LAST_PAIR_COL);
            frameDone <= accept && frame_end;
            if (emit) begin
                outPixel <= v_max;
            end
            if (accept) begin
                if (!col_cnt[0]) begin
                    hold_reg <= inPixel;
                end
                if (col_wrap) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    // Half-row line buffer; always written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            line_buf[buf_idx] <= h_max;
        end
    end

endmodule
